max7219_ctrl: RTL and testbench

- Command sequencer for the dual-MAX7219 daisy-chain SPI master.
- Drives the master's 16-bit address and data words, advancing one command per completed 32-bit transfer, signalled by the master's one-cycle finish pulse.
- After reset it issues the MAX7219 init sequence, then refreshes digit rows 1..8 continuously from a latched 128-bit frame.
- Intensity changes are re-sent between refresh passes.

---
 rtl/max7219_ctrl.sv | 151 +++++++++++++++
 tb/tb_max7219_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/max7219_ctrl.sv
// Command sequencer for a dual-MAX7219 daisy chain: it runs the init sequence, then
// refreshes rows 1..8 from a latched frame, re-sending intensity between passes.
//
// state    | meaning
// S_INIT   | init commands, idx_q = step 0..4
// S_ROW    | refresh, idx_q = row-1 (0..7)
// S_INTENS | intensity update issued between passes
module max7219_ctrl #(
  parameter logic [2:0] INIT_SCAN_LIMIT = 3'd7,
  parameter logic [7:0] INIT_DECODE     = 8'h00
) (
  input  logic         sck,
  input  logic         rst,
  input  logic         finish,
  input  logic [127:0] frame_in,
  input  logic         frame_valid,
  output logic         frame_ready,
  input  logic [3:0]   intensity,
  output logic [15:0]  address,
  output logic [15:0]  data,
  output logic         init_done,
  output logic         pass_done
);

  localparam logic [1:0] S_INIT   = 2'd0;
  localparam logic [1:0] S_ROW    = 2'd1;
  localparam logic [1:0] S_INTENS = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [2:0]   idx_q, idx_d;
  logic [15:0]  address_q, address_d;
  logic [15:0]  data_q, data_d;
  logic         init_done_q, init_done_d;
  logic         pass_done_q, pass_done_d;
  logic [127:0] frame_q, frame_d;
  logic [3:0]   last_int_q, last_int_d;
  logic         go_row1;
  logic [2:0]   row_sel;
  logic [7:0]   row_num;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    address_d   = address_q;
    data_d      = data_q;
    init_done_d = init_done_q;
    pass_done_d = 1'b0;
    frame_d     = frame_q;
    last_int_d  = last_int_q;
    go_row1     = 1'b0;
    frame_ready = 1'b0;
    row_sel     = idx_q + 3'd1;
    row_num     = {5'b0, idx_q} + 8'd2;

    if (finish) begin
      case (state_q)
        S_INIT: begin
          if (idx_q == 3'd4) begin
            init_done_d = 1'b1;
            go_row1     = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            case (idx_q)
              3'd0: begin
                address_d = 16'h0B0B;
                data_d    = {2{5'b0, INIT_SCAN_LIMIT}};
              end
              3'd1: begin
                address_d = 16'h0909;
                data_d    = {2{INIT_DECODE}};
              end
              3'd2: begin
                address_d  = 16'h0A0A;
                data_d     = {2{4'h0, intensity}};
                last_int_d = intensity;
              end
              default: begin
                address_d = 16'h0C0C;
                data_d    = 16'h0101;
              end
            endcase
          end
        end
        S_ROW: begin
          if (idx_q == 3'd7) begin
            pass_done_d = 1'b1;
            if (intensity != last_int_q) begin
              state_d    = S_INTENS;
              address_d  = 16'h0A0A;
              data_d     = {2{4'h0, intensity}};
              last_int_d = intensity;
            end else begin
              go_row1 = 1'b1;
            end
          end else begin
            idx_d     = row_sel;
            address_d = {row_num, row_num};
            data_d    = frame_q[{row_sel, 4'b0} +: 16];
          end
        end
        S_INTENS: go_row1 = 1'b1;
        default: begin
          state_d = S_INIT;
          idx_d   = 3'd0;
        end
      endcase
    end

    // Row 1 is the only place a new frame may enter, so a pass never mixes frames.
    if (go_row1) begin
      frame_ready = 1'b1;
      state_d     = S_ROW;
      idx_d       = 3'd0;
      address_d   = 16'h0101;
      if (frame_valid) begin
        frame_d = frame_in;
        data_d  = frame_in[15:0];
      end else begin
        data_d = frame_q[15:0];
      end
    end
  end

  always_ff @(posedge sck) begin
    if (rst) begin
      state_q     <= S_INIT;
      idx_q       <= 3'd0;
      address_q   <= 16'h0F0F;
      data_q      <= 16'h0000;
      init_done_q <= 1'b0;
      pass_done_q <= 1'b0;
      frame_q     <= '0;
      last_int_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      address_q   <= address_d;
      data_q      <= data_d;
      init_done_q <= init_done_d;
      pass_done_q <= pass_done_d;
      frame_q     <= frame_d;
      last_int_q  <= last_int_d;
    end
  end

  assign address   = address_q;
  assign data      = data_q;
  assign init_done = init_done_q;
  assign pass_done = pass_done_q;

endmodule

// File: tb/tb_max7219_ctrl.sv
// Randomized bench for max7219_ctrl against a queue-based command-stream model.
module tb_max7219_ctrl;
  logic         sck = 1'b0;
  logic         rst, finish, frame_valid, frame_ready;
  logic [127:0] frame_in;
  logic [3:0]   intensity;
  logic [15:0]  address, data;
  logic         init_done, pass_done;

  max7219_ctrl dut (
    .sck(sck), .rst(rst), .finish(finish), .frame_in(frame_in),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .intensity(intensity),
    .address(address), .data(data), .init_done(init_done), .pass_done(pass_done)
  );

  always #5 sck = ~sck;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: the current command, plus a queue of commands still to come.
  logic [31:0]  m_q[$];
  logic [31:0]  m_cur;
  int           m_phase;   // 0 init, 1 refresh, 2 intensity update
  logic         m_init_done, m_pass_done, m_ready;
  logic [3:0]   m_last;
  logic [127:0] m_frame;

  task automatic m_reset();
    m_q.delete();
    m_q.push_back(32'h0B0B_0707);
    m_q.push_back(32'h0909_0000);
    m_q.push_back(32'h0A0A_0000);
    m_q.push_back(32'h0C0C_0101);
    m_cur       = 32'h0F0F_0000;
    m_phase     = 0;
    m_init_done = 1'b0;
    m_pass_done = 1'b0;
    m_last      = 4'h0;
    m_frame     = '0;
  endtask

  task automatic m_start_pass();
    m_ready = 1'b1;
    if (frame_valid) m_frame = frame_in;
    for (int r = 1; r <= 8; r++)
      m_q.push_back({8'(r), 8'(r), m_frame[(r-1)*16 +: 16]});
    m_cur   = m_q.pop_front();
    m_phase = 1;
  endtask

  task automatic m_finish();
    m_pass_done = (m_phase == 1) && (m_cur[31:16] == 16'h0808);
    if (m_q.size() > 0) begin
      m_cur = m_q.pop_front();
      if (m_phase == 0 && m_cur[31:16] == 16'h0A0A) begin
        m_cur[15:0] = {2{4'h0, intensity}};
        m_last      = intensity;
      end
    end else if (m_phase == 0) begin
      m_init_done = 1'b1;
      m_start_pass();
    end else if (m_phase == 1 && intensity != m_last) begin
      m_cur   = {16'h0A0A, {2{4'h0, intensity}}};
      m_last  = intensity;
      m_phase = 2;
    end else begin
      m_start_pass();
    end
  endtask

  // Inputs are already set at a negedge; predict, cross the posedge, compare.
  task automatic step();
    #1;
    m_ready     = 1'b0;
    m_pass_done = 1'b0;
    if (rst) m_reset();
    else if (finish) m_finish();
    chk("frame_ready", {31'b0, frame_ready}, {31'b0, m_ready});
    @(posedge sck);
    @(negedge sck);
    chk("address", {16'b0, address}, {16'b0, m_cur[31:16]});
    chk("data", {16'b0, data}, {16'b0, m_cur[15:0]});
    chk("init_done", {31'b0, init_done}, {31'b0, m_init_done});
    chk("pass_done", {31'b0, pass_done}, {31'b0, m_pass_done});
  endtask

  initial begin
    logic accepted;
    rst = 1'b1; finish = 1'b0; frame_valid = 1'b1; intensity = 4'h5;
    frame_in = 128'h0102030405060708090A0B0C0D0E0F10;
    m_reset();
    @(negedge sck);
    step();
    step();
    rst = 1'b0;
    // Init and two full passes at the master's real 34-cycle cadence.
    for (int c = 0; c < 23; c++) begin
      for (int k = 0; k < 33; k++) begin
        finish = 1'b0;
        step();
      end
      finish = 1'b1;
      step();
      if (m_ready) frame_valid = 1'b0;
    end
    finish = 1'b0;
    step();
    // Randomized operation with compressed finish spacing.
    for (int c = 0; c < 6000; c++) begin
      rst    = ($urandom_range(0, 799) == 0);
      finish = !rst && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 29) == 0)
        intensity = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'h9;
      if (!frame_valid && $urandom_range(0, 5) == 0) begin
        frame_valid = 1'b1;
        frame_in    = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      accepted = m_ready && frame_valid;
      if (accepted) frame_valid = ($urandom_range(0, 3) == 0);
      if (accepted && frame_valid) frame_in = {$urandom, $urandom, $urandom, $urandom};
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
